// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write bypass,
// optional hardwired r0, per-register pending bits and a post-reset clear.
//
// Ports:
//   clk, rst_       clock, synchronous active-high reset
//   we_i/waddr_i/wdata_i   NWR write ports (packed, port k at slice k)
//   rsv_i/rsv_addr_i       reserve request, sets a pending bit
//   raddr_i/rdata_o/rbusy_o NRD combinational read ports
//   ready_o         high once every entry has been cleared
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREGS    = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst_,
  input  logic [NWR-1:0]      we_i,
  input  logic [NWR*AW-1:0]   waddr_i,
  input  logic [NWR*XLEN-1:0] wdata_i,
  input  logic                rsv_i,
  input  logic [AW-1:0]       rsv_addr_i,
  input  logic [NRD*AW-1:0]   raddr_i,
  output logic [NRD*XLEN-1:0] rdata_o,
  output logic [NRD-1:0]      rbusy_o,
  output logic                ready_o
);

  localparam logic [0:0] S_CLEAR = 1'b0;
  localparam logic [0:0] S_READY = 1'b1;

  localparam logic [AW:0] CNT_LAST = (AW+1)'(NREGS - 1);

  logic [0:0]      state_q, state_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] pend_q, pend_d;

  // Per-port write view with dropped r0 writes already masked off.
  logic [AW-1:0]   wa   [NWR];
  logic [XLEN-1:0] wd   [NWR];
  logic            wv   [NWR];

  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wa[k] = waddr_i[k*AW +: AW];
      wd[k] = wdata_i[k*XLEN +: XLEN];
      wv[k] = we_i[k] && (state_q == S_READY)
              && !((ZERO_REG == 1) && (wa[k] == '0));
    end
  end

  logic rsv_ok;

  assign rsv_ok = rsv_i && (state_q == S_READY)
                  && !((ZERO_REG == 1) && (rsv_addr_i == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    regs_d  = regs_q;
    pend_d  = pend_q;
    if (state_q == S_CLEAR) begin
      regs_d[cnt_q[AW-1:0]] = '0;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CNT_LAST) begin
        state_d = S_READY;
      end
    end else begin
      // Ascending loop: the highest-index port wins on conflicts.
      for (int k = 0; k < NWR; k++) begin
        if (wv[k]) begin
          regs_d[wa[k]] = wd[k];
          pend_d[wa[k]] = 1'b0;
        end
      end
      // Reserve is applied after writes so it wins on a tie.
      if (rsv_ok) begin
        pend_d[rsv_addr_i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      state_q <= S_CLEAR;
      cnt_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
    end
  end

  // Array contents need no reset: the clear sequencer zeroes them.
  always_ff @(posedge clk) begin
    if (!rst_) begin
      regs_q <= regs_d;
    end
  end

  logic [AW-1:0]   ra  [NRD];
  logic            hit [NRD];
  logic [XLEN-1:0] bd  [NRD];
  logic            rh  [NRD];

  always_comb begin
    rdata_o = '0;
    rbusy_o = '0;
    for (int j = 0; j < NRD; j++) begin
      ra[j]  = raddr_i[j*AW +: AW];
      hit[j] = 1'b0;
      bd[j]  = '0;
      rh[j]  = rsv_i && (rsv_addr_i == ra[j]);
      for (int k = 0; k < NWR; k++) begin
        if (wv[k] && (wa[k] == ra[j])) begin
          hit[j] = 1'b1;
          bd[j]  = wd[k];
        end
      end
      if (state_q == S_CLEAR) begin
        rdata_o[j*XLEN +: XLEN] = '0;
        rbusy_o[j] = 1'b0;
      end else begin
        if ((ZERO_REG == 1) && (ra[j] == '0)) begin
          rdata_o[j*XLEN +: XLEN] = '0;
        end else if ((BYPASS == 1) && hit[j]) begin
          rdata_o[j*XLEN +: XLEN] = bd[j];
        end else begin
          rdata_o[j*XLEN +: XLEN] = regs_q[ra[j]];
        end
        // A same-cycle write retires the hazard unless re-reserved.
        if ((BYPASS == 1) && hit[j] && !rh[j]) begin
          rbusy_o[j] = 1'b0;
        end else begin
          rbusy_o[j] = pend_q[ra[j]];
        end
      end
    end
  end

  assign ready_o = (state_q == S_READY);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed test of regfile_mp; u0 uses default
// parameters, u1 has 3 read ports, no bypass and no hardwired r0.
module tb_regfile_mp;

  logic        clk;
  logic        rst_;
  logic [1:0]  we;
  logic [9:0]  waddr;
  logic [63:0] wdata;
  logic        rsv;
  logic [4:0]  rsv_addr;
  logic [9:0]  ra0;
  logic [63:0] rd0;
  logic [1:0]  rb0;
  logic        rdy0;
  logic [14:0] ra1;
  logic [95:0] rd1;
  logic [2:0]  rb1;
  logic        rdy1;

  int checks = 0;
  int errors = 0;

  regfile_mp u0 (
    .clk(clk), .rst_(rst_),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr),
    .raddr_i(ra0), .rdata_o(rd0), .rbusy_o(rb0),
    .ready_o(rdy0)
  );

  regfile_mp #(
    .NRD(3), .ZERO_REG(0), .BYPASS(0)
  ) u1 (
    .clk(clk), .rst_(rst_),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .rsv_i(rsv), .rsv_addr_i(rsv_addr),
    .raddr_i(ra1), .rdata_o(rd1), .rbusy_o(rb1),
    .ready_o(rdy1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_ = 1'b1;
    we = '0; waddr = '0; wdata = '0;
    rsv = 1'b0; rsv_addr = '0;
    ra0 = '0; ra1 = '0;
    step();
    #1;
    chk("rst_ready0", {31'b0, rdy0}, 32'd0);
    chk("rst_ready1", {31'b0, rdy1}, 32'd0);
    chk("rst_rdata0", rd0[31:0], 32'd0);
    chk("rst_rbusy0", {30'b0, rb0}, 32'd0);
    chk("rst_rdata1", rd1[31:0], 32'd0);

    // Clear starts; writes to r3 must be ignored throughout.
    rst_ = 1'b0;
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'hAAAA};
    for (int i = 0; i < 10; i++) step();
    rst_ = 1'b1;
    step();
    chk("midclr_ready", {31'b0, rdy0}, 32'd0);
    rst_ = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("clr_wait", {31'b0, rdy0}, 32'd0);
      step();
    end
    chk("clr_done0", {31'b0, rdy0}, 32'd1);
    chk("clr_done1", {31'b0, rdy1}, 32'd1);
    we = '0;
    ra0 = {5'd3, 5'd3}; ra1 = {5'd3, 5'd3, 5'd3};
    #1;
    chk("clr_r3_u0", rd0[31:0], 32'd0);
    chk("clr_r3_u1", rd1[31:0], 32'd0);
    chk("clr_busy", {30'b0, rb0}, 32'd0);

    // Preload r1=1, r2=2, r3=3.
    we = 2'b11; waddr = {5'd2, 5'd1}; wdata = {32'd2, 32'd1};
    step();
    we = 2'b01; waddr = {5'd0, 5'd3}; wdata = {32'd0, 32'd3};
    step();
    we = '0;
    ra0 = {5'd2, 5'd1};
    #1;
    chk("pre_r1", rd0[31:0], 32'd1);
    chk("pre_r2", rd0[63:32], 32'd2);

    // Port1 writes r2=9 while reading r1/r2/r3.
    ra0 = {5'd3, 5'd2};
    ra1 = {5'd3, 5'd2, 5'd1};
    we = 2'b10; waddr = {5'd2, 5'd0}; wdata = {32'd9, 32'd0};
    #1;
    chk("mp_byp_u0", rd0[31:0], 32'd9);
    chk("mp_u1_p0", rd1[31:0], 32'd1);
    chk("mp_u1_p1_old", rd1[63:32], 32'd2);
    chk("mp_u1_p2", rd1[95:64], 32'd3);
    step();
    we = '0;
    #1;
    chk("mp_u1_p1_new", rd1[63:32], 32'd9);

    // Same-cycle conflict on r5.
    we = 2'b11; waddr = {5'd5, 5'd5};
    wdata = {32'h2222, 32'h1111};
    ra0 = {5'd5, 5'd5}; ra1 = {5'd0, 5'd0, 5'd5};
    #1;
    chk("conf_byp_u0", rd0[31:0], 32'h2222);
    chk("conf_old_u1", rd1[31:0], 32'd0);
    step();
    we = '0;
    #1;
    chk("conf_u0", rd0[31:0], 32'h2222);
    chk("conf_u1", rd1[31:0], 32'h2222);

    // r0 write and reserve.
    we = 2'b01; waddr = {5'd0, 5'd0};
    wdata = {32'd0, 32'hDEADBEEF};
    rsv = 1'b1; rsv_addr = 5'd0;
    ra0 = {5'd0, 5'd0}; ra1 = {5'd0, 5'd0, 5'd0};
    #1;
    chk("zero_rd_p0", rd0[31:0], 32'd0);
    chk("zero_rd_p1", rd0[63:32], 32'd0);
    chk("zero_busy", {30'b0, rb0}, 32'd0);
    step();
    we = '0; rsv = 1'b0;
    #1;
    chk("zero_rd_after", rd0[31:0], 32'd0);
    chk("zero_busy_after", {30'b0, rb0}, 32'd0);
    chk("nozero_rd", rd1[31:0], 32'hDEADBEEF);
    chk("nozero_busy", {31'b0, rb1[0]}, 32'd1);

    // Scoreboard on r7.
    rsv = 1'b1; rsv_addr = 5'd7;
    step();
    rsv = 1'b0;
    ra0 = {5'd7, 5'd7}; ra1 = {5'd0, 5'd0, 5'd7};
    #1;
    chk("sb_rsv_u0", {30'b0, rb0}, 32'd3);
    chk("sb_rsv_u1", {31'b0, rb1[0]}, 32'd1);
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h42};
    #1;
    chk("sb_wr_busy_u0", {30'b0, rb0}, 32'd0);
    chk("sb_wr_data_u0", rd0[31:0], 32'h42);
    chk("sb_wr_busy_u1", {31'b0, rb1[0]}, 32'd1);
    chk("sb_wr_data_u1", rd1[31:0], 32'd0);
    step();
    we = '0;
    #1;
    chk("sb_after_u0", {30'b0, rb0}, 32'd0);
    chk("sb_after_u1", {31'b0, rb1[0]}, 32'd0);
    chk("sb_after_d1", rd1[31:0], 32'h42);
    rsv = 1'b1; rsv_addr = 5'd7;
    we = 2'b01; waddr = {5'd0, 5'd7}; wdata = {32'd0, 32'h55};
    step();
    rsv = 1'b0; we = '0;
    #1;
    chk("sb_tie_busy", {30'b0, rb0}, 32'd3);
    chk("sb_tie_data", rd0[31:0], 32'h55);

    // Reset in operation clears pending and output state.
    rst_ = 1'b1;
    step();
    #1;
    chk("rst2_ready", {31'b0, rdy0}, 32'd0);
    chk("rst2_busy", {30'b0, rb0}, 32'd0);
    chk("rst2_rdata", rd0[31:0], 32'd0);
    chk("rst2_busy_u1", {29'b0, rb1}, 32'd0);
    rst_ = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
